// File: rtl/baud_rate_generator_pkg.sv
// Shared SPI definitions: mode encodings, divisor width and the half-period helper.
package baud_rate_generator_pkg;

    localparam int unsigned DivWidth = 12;

    typedef enum logic [1:0] {
        ModeRun  = 2'b00,
        ModeWait = 2'b01,
        ModeStop = 2'b10
    } spi_mode_e;

    // Half sclk period in pclk cycles: (sppr+1) << spr, at most 8 << 7 = 1024.
    function automatic logic [DivWidth-1:0] half_period(input logic [2:0] sppr,
                                                        input logic [2:0] spr);
        logic [DivWidth-1:0] base;
        base = {{(DivWidth-3){1'b0}}, sppr} + DivWidth'(1);
        return base << spr;
    endfunction

endpackage

// File: rtl/baud_rate_generator.sv
// SPI baud rate generator: divides pclk down to sclk and emits one-pclk strobes
// ahead of each sclk edge for the shift-in and shift-out logic.
module baud_rate_generator
    import baud_rate_generator_pkg::*;
(
    input  logic                pclk,
    input  logic                preset_n,
    input  logic [1:0]          spi_mode,
    input  logic                spiswai,
    input  logic [2:0]          sppr,
    input  logic [2:0]          spr,
    input  logic                cpol,
    input  logic                cpha,
    input  logic                ss,
    output logic                sclk,
    output logic                miso_receive_sclk,
    output logic                miso_receive_sclk0,
    output logic                mosi_send_sclk,
    output logic                mosi_send_sclk0,
    output logic [DivWidth-1:0] baud_rate_divisor
);

    logic [DivWidth-1:0] half;
    logic [DivWidth-1:0] half_m1;
    logic [DivWidth-1:0] count_q, count_d;
    logic                sclk_q, sclk_d;
    logic                run;
    logic                run_eff;
    logic                at_limit;
    logic                sclk_edge;

    // cpha only matters to the consumers of the strobes.
    logic unused_cpha;
    assign unused_cpha = cpha;

    // Divider setting and run qualification.
    always_comb begin
        half              = half_period(sppr, spr);
        half_m1           = half - DivWidth'(1);
        baud_rate_divisor = half << 1;
        run               = !ss && ((spi_mode == ModeRun) ||
                                    ((spi_mode == ModeWait) && !spiswai));
        // Strobes must stay low while reset is held, so gate run with it.
        run_eff           = run && preset_n;
        // >= rather than == so a shrinking half toggles at once instead of wrapping.
        at_limit          = (count_q >= half_m1);
        sclk_edge         = run_eff && at_limit;
    end

    // Next-state for the period counter and sclk.
    always_comb begin
        count_d = count_q;
        sclk_d  = sclk_q;
        if (!run) begin
            count_d = '0;
            sclk_d  = cpol;
        end else if (at_limit) begin
            count_d = '0;
            sclk_d  = ~sclk_q;
        end else begin
            count_d = count_q + DivWidth'(1);
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            count_q <= '0;
            sclk_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            sclk_q  <= sclk_d;
        end
    end

    // Strobe decode: the pair fired depends on which sclk edge comes next.
    always_comb begin
        miso_receive_sclk  = 1'b0;
        miso_receive_sclk0 = 1'b0;
        mosi_send_sclk     = 1'b0;
        mosi_send_sclk0    = 1'b0;
        if (sclk_edge) begin
            if (!sclk_q) begin
                // Rising edge follows.
                miso_receive_sclk = 1'b1;
                mosi_send_sclk0   = 1'b1;
            end else begin
                // Falling edge follows.
                miso_receive_sclk0 = 1'b1;
                mosi_send_sclk     = 1'b1;
            end
        end
    end

    assign sclk = sclk_q;

endmodule

// File: doc/baud_rate_generator.md
BAUD_RATE_GENERATOR -- requirements
Module: baud_rate_generator

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset; ports are named pclk and preset_n.
REQ-002 pclk  input  1  system clock; all state updates on its rising edge.
REQ-003 preset_n  input  1  asynchronous active-low reset.
REQ-004 spi_mode  input  2  operating mode: 00 run, 01 wait, 10/11 stop.
REQ-005 spiswai  input  1  1 = SPI stops while in wait mode.
REQ-006 sppr  input  3  baud prescaler select.
REQ-007 spr  input  3  baud rate select.
REQ-008 cpol  input  1  sclk idle level.
REQ-009 cpha  input  1  clock phase; used only to qualify documentation of strobe pairing, no internal effect.
REQ-010 ss  input  1  active-low slave select from the master controller.
REQ-011 sclk  output  1  SPI serial clock.
REQ-012 miso_receive_sclk  output  1  one-pclk strobe preceding a sclk rising edge (sample, modes 0/3).
REQ-013 miso_receive_sclk0  output  1  one-pclk strobe preceding a sclk falling edge (sample, modes 1/2).
REQ-014 mosi_send_sclk  output  1  one-pclk strobe preceding a sclk falling edge (shift-out, modes 0/3).
REQ-015 mosi_send_sclk0  output  1  one-pclk strobe preceding a sclk rising edge (shift-out, modes 1/2).
REQ-016 baud_rate_divisor  output  12  (sppr+1) * 2^(spr+1), combinational.

Function
REQ-017 half = (sppr+1) << spr; range 1..1024; 12-bit arithmetic, no overflow.
REQ-018 run = !ss && (spi_mode==00 || (spi_mode==01 && !spiswai)).
REQ-019 12-bit counter count: when !run, count<=0; when run and count >= half-1, count<=0; otherwise count<=count+1.
REQ-020 When !run, sclk<=cpol on the next pclk edge; cpol changes while idle are followed within one cycle.
REQ-021 When run and count >= half-1, sclk<=~sclk; sclk otherwise holds.
REQ-022 edge = run && (count >= half-1); all four strobes are 0 when edge is 0.
REQ-023 When edge and sclk==0: miso_receive_sclk=1 and mosi_send_sclk0=1; the other two strobes are 0.
REQ-024 When edge and sclk==1: miso_receive_sclk0=1 and mosi_send_sclk=1; the other two strobes are 0.
REQ-025 Strobes are decoded from registered count/sclk plus inputs; each is high for exactly one pclk per qualifying sclk edge.
REQ-026 Period boundary: with half=1, sclk toggles every pclk and one strobe pair fires every cycle, alternating.
REQ-027 Mid-transfer sppr/spr change: the new half applies immediately; if count >= new half-1, the toggle occurs on the next edge (no wrap-around stall).
REQ-028 ss rising mid-period: the count is abandoned, sclk returns to cpol next cycle, and no strobe fires in that cycle.
REQ-029 First edge after ss falls occurs half pclk cycles after run asserts; it is the leading edge relative to cpol.

Reset
REQ-030 While preset_n==0: count=0, sclk=0; strobes SHALL be 0 (decoded with run forced 0).
REQ-031 The first cycle after reset release loads sclk<=cpol if !run.
REQ-032 Reset asserted mid-operation SHALL take effect immediately, independent of pclk.

Structure
REQ-033 The shared SPI package SHALL hold the spi_mode encodings (RUN=00, WAIT=01, STOP=10) and the divisor width constant (12).
REQ-034 The module is flat with no sub-module; the strobe decode is in a single combinational block.

Verification
REQ-035 sppr=0, spr=0, cpol=0, ss=0, mode run -> sclk toggles every pclk; baud_rate_divisor=2; miso_receive_sclk and mosi_send_sclk alternate every cycle.
REQ-036 sppr=2, spr=1, cpol=1 -> half=6, divisor=12; sclk period 12 pclk; idle high; the first edge is falling, preceded by a miso_receive_sclk0/mosi_send_sclk pulse.
REQ-037 Mode wait, spiswai=1 -> sclk held at cpol, count=0, no strobes; spiswai=0 -> toggling resumes after half cycles.
REQ-038 ss deasserted at count=3 of half=6 -> next cycle sclk=cpol, count=0, strobes 0; reassert -> first edge 6 cycles later.
REQ-039 spr changed 3->0 at count=5 (sppr=0) -> toggle on the next pclk, then a period of 2 pclk.
REQ-040 preset_n pulsed low mid-period -> sclk=0, count=0, strobes 0 asynchronously; after release sclk=cpol.
